// File: rtl/bool_chk_pkg.sv
// Shared types and helpers for the boolean response checker.
package bool_chk_pkg;

  localparam int IDX_W   = 3;
  localparam int NUM_VEC = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STABLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit of a truth table addressed by an input-vector index.
  function automatic logic tt_bit(input logic [NUM_VEC-1:0] tbl,
                                  input logic [IDX_W-1:0]   idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/stable_detect.sv
// Input register, vector-change detect and settle counter. Emits one
// sample_req pulse per stable period once the vector has held SETTLE cycles.
module stable_detect
  import bool_chk_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             e,
  output logic             sample_req,
  output logic [IDX_W-1:0] idx_q,
  output logic             e_q
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic [IDX_W-1:0] prev_q;
  logic [CNT_W-1:0] settle_cnt;
  logic             taken;
  logic             changed;

  assign changed    = (idx_q != prev_q);
  assign sample_req = !clr && !changed && !taken && (settle_cnt == CNT_LAST);

  // Register the observed interface once; keep the previous index for change detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      e_q    <= 1'b0;
      prev_q <= '0;
    end else begin
      idx_q  <= {a, b, c};
      e_q    <= e;
      prev_q <= idx_q;
    end
  end

  // Count stable cycles; a change or a new run re-arms the one-shot sample.
  always_ff @(posedge clk) begin
    if (rst || clr || changed) begin
      settle_cnt <= '0;
      taken      <= 1'b0;
    end else begin
      if (settle_cnt != CNT_LAST)
        settle_cnt <= settle_cnt + 1'b1;
      if (sample_req)
        taken <= 1'b1;
    end
  end

endmodule

// File: rtl/bool_response_checker.sv
// Rebuilds a 3-input DUT truth table from observed stimulus/response and
// compares it to EXP_TT, flagging mismatch, inconsistency and timeout.
//
// state  | meaning
// IDLE   | waiting for start after reset
// STABLE | run active, waiting for a settled vector
// SAMPLE | one cycle: record the latched index/response
// DONE   | run finished, results held until next start
module bool_response_checker
  import bool_chk_pkg::*;
#(
  parameter int          SETTLE  = 4,
  parameter int          TIMEOUT = 1024,
  parameter logic [7:0]  EXP_TT  = 8'hEA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       e,
  output logic [7:0] tt,
  output logic [7:0] seen,
  output logic [3:0] vec_count,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       mismatch,
  output logic [2:0] err_idx,
  output logic       incons,
  output logic       timeout
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             sample_req;
  logic [IDX_W-1:0] idx_q;
  logic             e_q;
  logic [IDX_W-1:0] smp_idx;
  logic             smp_e;
  logic [TO_W-1:0]  to_cnt;
  logic             start_run;
  logic             new_idx;
  logic             to_hit;
  logic             cover_done;
  logic [3:0]       vec_count_nxt;

  assign start_run = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == STABLE) || (state == SAMPLE);
  assign pass      = done && (seen == 8'hFF) && !mismatch && !incons && !timeout;

  stable_detect #(
    .SETTLE (SETTLE)
  ) u_stable (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_run),
    .a          (a),
    .b          (b),
    .c          (c),
    .e          (e),
    .sample_req (sample_req),
    .idx_q      (idx_q),
    .e_q        (e_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; coverage completion takes precedence over timeout.
  always_comb begin
    state_nxt     = state;
    new_idx       = !tt_bit(seen, smp_idx);
    vec_count_nxt = (new_idx && (vec_count != 4'(NUM_VEC))) ? vec_count + 4'd1 : vec_count;
    to_hit        = (to_cnt == TO_LAST);
    cover_done    = (state == SAMPLE) && (vec_count_nxt == 4'(NUM_VEC));
    unique case (state)
      IDLE:    if (start) state_nxt = STABLE;
      STABLE:  if (to_hit) state_nxt = DONE;
               else if (sample_req) state_nxt = SAMPLE;
      SAMPLE:  if (cover_done || to_hit) state_nxt = DONE;
               else state_nxt = STABLE;
      DONE:    if (start) state_nxt = STABLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture table, coverage, error flags and the run timeout counter.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      tt        <= '0;
      seen      <= '0;
      vec_count <= '0;
      mismatch  <= 1'b0;
      err_idx   <= '0;
      incons    <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
      to_cnt    <= '0;
      smp_idx   <= '0;
      smp_e     <= 1'b0;
    end else begin
      if (busy)
        to_cnt <= to_cnt + 1'b1;
      // Latch the settled vector so SAMPLE is immune to the next input change.
      if (state == STABLE) begin
        smp_idx <= idx_q;
        smp_e   <= e_q;
      end
      if (state == SAMPLE) begin
        if (new_idx) begin
          tt[smp_idx]   <= smp_e;
          seen[smp_idx] <= 1'b1;
          vec_count     <= vec_count_nxt;
        end else if (tt_bit(tt, smp_idx) != smp_e) begin
          incons <= 1'b1;
        end
        if (smp_e != tt_bit(EXP_TT, smp_idx)) begin
          mismatch <= 1'b1;
          err_idx  <= (mismatch && (err_idx < smp_idx)) ? err_idx : smp_idx;
        end
      end
      if (busy && (state_nxt == DONE)) begin
        done    <= 1'b1;
        timeout <= !cover_done;
      end
    end
  end

endmodule

// File: tb/tb_bool_response_checker.sv
// Self-checking bench: directed scenarios plus randomized segment runs,
// checked against a segment-level model of what the checker should record.
module tb_bool_response_checker;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst, start, a, b, c, e;

  logic [7:0] tt, seen, t_tt, t_seen;
  logic [3:0] vec_count, t_vec_count;
  logic [2:0] err_idx, t_err_idx;
  logic busy, done, pass, mismatch, incons, timeout;
  logic t_busy, t_done, t_pass, t_mismatch, t_incons, t_timeout;

  bool_response_checker #(.SETTLE(SETTLE), .TIMEOUT(1024), .EXP_TT(8'hEA)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .e(e),
    .tt(tt), .seen(seen), .vec_count(vec_count), .busy(busy), .done(done),
    .pass(pass), .mismatch(mismatch), .err_idx(err_idx), .incons(incons),
    .timeout(timeout));

  bool_response_checker #(.SETTLE(SETTLE), .TIMEOUT(200), .EXP_TT(8'hEA)) u_to (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .e(e),
    .tt(t_tt), .seen(t_seen), .vec_count(t_vec_count), .busy(t_busy), .done(t_done),
    .pass(t_pass), .mismatch(t_mismatch), .err_idx(t_err_idx), .incons(t_incons),
    .timeout(t_timeout));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_tt = 8'hEA;
  logic [2:0] seg_v[$];
  logic       seg_e[$];
  int         seg_h[$];
  int         played;
  int         cyc;
  int         t_done_at;

  function automatic logic good_e(input logic [2:0] v);
    return (v[2] & v[1]) | v[0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic new_run();
    seg_v.delete(); seg_e.delete(); seg_h.delete();
    played = 0; cyc = 0; t_done_at = -1;
  endtask

  task automatic push(input logic [2:0] v, input logic ev, input int h);
    seg_v.push_back(v); seg_e.push_back(ev); seg_h.push_back(h);
  endtask

  // Drive queued segments from a negedge; the first one of a run carries start.
  task automatic play(input bit with_start);
    while (played < seg_v.size()) begin
      {a, b, c} = seg_v[played];
      e = seg_e[played];
      if (with_start && played == 0) start = 1'b1;
      for (int k = 0; k < seg_h[played]; k++) begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
        if (t_done && t_done_at < 0) t_done_at = cyc;
      end
      played++;
    end
  endtask

  // Model: a segment held longer than SETTLE yields exactly one sample.
  task automatic check_run(input string tag);
    logic [7:0] m_tt, m_seen;
    int m_cnt;
    logic m_mis, m_inc;
    logic [2:0] m_err, v;
    logic ev;
    m_tt = '0; m_seen = '0; m_cnt = 0; m_mis = 0; m_inc = 0; m_err = '0;
    for (int i = 0; i < seg_v.size(); i++) begin
      if (seg_h[i] > SETTLE && m_cnt < 8) begin
        v = seg_v[i]; ev = seg_e[i];
        if (!m_seen[v]) begin
          m_tt[v] = ev; m_seen[v] = 1'b1; m_cnt++;
        end else if (m_tt[v] != ev) begin
          m_inc = 1'b1;
        end
        if (ev != exp_tt[v]) begin
          if (!m_mis || v < m_err) m_err = v;
          m_mis = 1'b1;
        end
      end
    end
    for (int k = 0; k < 60 && !done; k++) @(negedge clk);
    check({tag, ".done"},      8'(done), 8'd1);
    check({tag, ".busy"},      8'(busy), 8'd0);
    check({tag, ".tt"},        tt, m_tt);
    check({tag, ".seen"},      seen, m_seen);
    check({tag, ".vec_count"}, 8'(vec_count), 8'(m_cnt));
    check({tag, ".mismatch"},  8'(mismatch), 8'(m_mis));
    if (m_mis) check({tag, ".err_idx"}, 8'(err_idx), 8'(m_err));
    check({tag, ".incons"},    8'(incons), 8'(m_inc));
    check({tag, ".timeout"},   8'(timeout), 8'd0);
    check({tag, ".pass"},      8'(pass), 8'((m_seen == 8'hFF) && !m_mis && !m_inc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".tt"},        tt, 8'h00);
    check({tag, ".seen"},      seen, 8'h00);
    check({tag, ".vec_count"}, 8'(vec_count), 8'd0);
    check({tag, ".busy"},      8'(busy), 8'd0);
    check({tag, ".done"},      8'(done), 8'd0);
    check({tag, ".pass"},      8'(pass), 8'd0);
    check({tag, ".mismatch"},  8'(mismatch), 8'd0);
    check({tag, ".err_idx"},   8'(err_idx), 8'd0);
    check({tag, ".incons"},    8'(incons), 8'd0);
    check({tag, ".timeout"},   8'(timeout), 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_run(input string tag);
    logic [2:0] perm[8];
    logic [2:0] last, v, tmp;
    int j;
    for (int i = 0; i < 8; i++) perm[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    new_run();
    last = {a, b, c};
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do v = 3'($urandom_range(0, 7)); while (v == last || v == perm[i]);
        push(v, 1'($urandom_range(0, 1)), $urandom_range(2, 3));
        last = v;
      end
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        v = perm[$urandom_range(0, i - 1)];
        if (v != last) begin
          push(v, good_e(v) ^ 1'($urandom_range(0, 1)), $urandom_range(7, 10));
          last = v;
        end
      end
      push(perm[i], good_e(perm[i]) ^ ($urandom_range(0, 7) == 0), $urandom_range(7, 10));
      last = perm[i];
    end
    play(1'b1);
    check_run(tag);
  endtask

  initial begin
    start = 1'b0; {a, b, c} = 3'd0; e = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_reset();
    check_reset("reset");

    // Exhaustive walk with the correct DUT function.
    new_run();
    for (int v = 0; v < 8; v++) push(3'(v), good_e(3'(v)), 10);
    play(1'b1);
    check_run("walk");
    check("walk.tt_const", tt, 8'hEA);

    // DUT stuck at 0 on indices 5 and 3.
    new_run();
    for (int v = 0; v < 8; v++) push(3'(v), good_e(3'(v)) & !(v == 5 || v == 3), 10);
    play(1'b1);
    check_run("stuck");
    check("stuck.err_idx_const", 8'(err_idx), 8'd3);

    // Vector changing every 2 cycles never settles; 6-cycle holds do.
    new_run();
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 8; v++) push(3'(v), good_e(3'(v)), 2);
    play(1'b1);
    check("glitch.seen", seen, 8'h00);
    check("glitch.vec_count", 8'(vec_count), 8'd0);
    check("glitch.busy", 8'(busy), 8'd1);
    for (int v = 0; v < 8; v++) push(3'(v), good_e(3'(v)), 6);
    play(1'b0);
    check_run("glitch_then_hold");

    // Index 6 revisited with a flipped response.
    new_run();
    for (int v = 0; v < 7; v++) push(3'(v), good_e(3'(v)), 10);
    push(3'd5, good_e(3'd5), 10);
    push(3'd6, 1'b0, 10);
    push(3'd7, good_e(3'd7), 10);
    play(1'b1);
    check_run("incons");

    // Only indices 0..3 ever presented: the 200-cycle instance must time out.
    do_reset();
    new_run();
    for (int r = 0; r < 6; r++)
      for (int v = 0; v < 4; v++) push(3'(v), good_e(3'(v)), 10);
    play(1'b1);
    check("timeout.cycle", 8'(t_done_at), 8'd201);
    check("timeout.done", 8'(t_done), 8'd1);
    check("timeout.timeout", 8'(t_timeout), 8'd1);
    check("timeout.seen", t_seen, 8'h0F);
    check("timeout.vec_count", 8'(t_vec_count), 8'd4);
    check("timeout.pass", 8'(t_pass), 8'd0);
    check("timeout.busy", 8'(t_busy), 8'd0);

    // Reset in the middle of a run after three samples.
    do_reset();
    new_run();
    for (int v = 0; v < 3; v++) push(3'(v + 4), good_e(3'(v + 4)), 10);
    play(1'b1);
    check("midrst.seen_before", seen, 8'h70);
    check("midrst.busy_before", 8'(busy), 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    new_run();
    for (int v = 7; v >= 0; v--) push(3'(v), good_e(3'(v)), 9);
    play(1'b1);
    check_run("after_rst");
    check("after_rst.pass_const", 8'(pass), 8'd1);

    // Randomized runs with glitches, revisits and occasional wrong responses.
    for (int r = 0; r < 6; r++) random_run($sformatf("rand%0d", r));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
